// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_EX   = 2'b01;
    localparam fwd_sel_t FWD_MEM  = 2'b10;
    localparam fwd_sel_t FWD_WB   = 2'b11;

    // Write-back source code meaning "data comes from data memory" (a load).
    localparam logic [1:0] WD_SEL_DRAM = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand forwarding select; also flags the EX-load match that forms a load-use hazard.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       used_i,
    input  logic [4:0] wr_ex_i,
    input  logic [4:0] wr_mem_i,
    input  logic [4:0] wr_wb_i,
    input  logic       rf_we_ex_i,
    input  logic       rf_we_mem_i,
    input  logic       rf_we_wb_i,
    input  logic [1:0] wd_sel_ex_i,
    output fwd_sel_t   sel_o,
    output logic       load_use_o
);

    logic rs_valid;
    logic ex_match;
    logic mem_match;
    logic wb_match;

    assign rs_valid  = used_i && (rs_i != 5'd0);
    assign ex_match  = rs_valid && rf_we_ex_i  && (wr_ex_i  == rs_i);
    assign mem_match = rs_valid && rf_we_mem_i && (wr_mem_i == rs_i);
    assign wb_match  = rs_valid && rf_we_wb_i  && (wr_wb_i  == rs_i);

    // A load in EX has no data yet; older stages hold stale values, so nothing is forwarded.
    always_comb begin
        sel_o      = FWD_NONE;
        load_use_o = 1'b0;
        if (ex_match) begin
            if (wd_sel_ex_i == WD_SEL_DRAM) begin
                load_use_o = 1'b1;
            end else begin
                sel_o = FWD_EX;
            end
        end else if (mem_match) begin
            sel_o = FWD_MEM;
        end else if (wb_match) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls/flushes, operand forwarding, multi-cycle EX sequencing.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic       rs1_used_id_i,
    input  logic       rs2_used_id_i,
    input  logic [4:0] wr_ex_i,
    input  logic [4:0] wr_mem_i,
    input  logic [4:0] wr_wb_i,
    input  logic       rf_we_ex_i,
    input  logic       rf_we_mem_i,
    input  logic       rf_we_wb_i,
    input  logic [1:0] wd_sel_ex_i,
    input  logic [1:0] wd_sel_mem_i,
    input  logic       redirect_ex_i,
    input  logic       mc_start_ex_i,
    input  logic       mc_done_i,
    output logic       stall_pc_o,
    output logic       stall_if_id_o,
    output logic       stall_id_ex_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic       bubble_ex_mem_o,
    output logic [1:0] fwd_rD1_sel_o,
    output logic [1:0] fwd_rD2_sel_o,
    output logic       fwd_rD1e_o,
    output logic       fwd_rD2e_o,
    output logic       mc_busy_o,
    output logic       mc_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc_o,
    output logic [31:0] perf_flush_cnt_o,
    output logic [31:0] perf_lu_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    mc_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    fwd_sel_t fwd1_sel;
    fwd_sel_t fwd2_sel;
    logic     lu_rs1;
    logic     lu_rs2;
    logic     load_use;

    logic mc_enter;
    logic mc_abort;
    logic redirect_take;
    logic lu_take;

    // MEM always forwards its result, load data included, so its source code is not needed here.
    logic unused_wd_sel_mem;
    assign unused_wd_sel_mem = ^wd_sel_mem_i;

    fwd_unit u_fwd_rs1 (
        .rs_i        (rs1_id_i),
        .used_i      (rs1_used_id_i),
        .wr_ex_i     (wr_ex_i),
        .wr_mem_i    (wr_mem_i),
        .wr_wb_i     (wr_wb_i),
        .rf_we_ex_i  (rf_we_ex_i),
        .rf_we_mem_i (rf_we_mem_i),
        .rf_we_wb_i  (rf_we_wb_i),
        .wd_sel_ex_i (wd_sel_ex_i),
        .sel_o       (fwd1_sel),
        .load_use_o  (lu_rs1)
    );

    fwd_unit u_fwd_rs2 (
        .rs_i        (rs2_id_i),
        .used_i      (rs2_used_id_i),
        .wr_ex_i     (wr_ex_i),
        .wr_mem_i    (wr_mem_i),
        .wr_wb_i     (wr_wb_i),
        .rf_we_ex_i  (rf_we_ex_i),
        .rf_we_mem_i (rf_we_mem_i),
        .rf_we_wb_i  (rf_we_wb_i),
        .wd_sel_ex_i (wd_sel_ex_i),
        .sel_o       (fwd2_sel),
        .load_use_o  (lu_rs2)
    );

    assign fwd_rD1_sel_o = fwd1_sel;
    assign fwd_rD2_sel_o = fwd2_sel;
    assign fwd_rD1e_o    = (fwd1_sel != FWD_NONE);
    assign fwd_rD2e_o    = (fwd2_sel != FWD_NONE);
    assign load_use      = lu_rs1 || lu_rs2;

    always_comb begin
        stall_pc_o      = 1'b0;
        stall_if_id_o   = 1'b0;
        stall_id_ex_o   = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        bubble_ex_mem_o = 1'b0;
        mc_enter        = 1'b0;
        mc_abort        = 1'b0;
        redirect_take   = 1'b0;
        lu_take         = 1'b0;
        case (state_q)
            RUN: begin
                if (mc_start_ex_i && !mc_done_i) begin
                    mc_enter        = 1'b1;
                    stall_pc_o      = 1'b1;
                    stall_if_id_o   = 1'b1;
                    stall_id_ex_o   = 1'b1;
                    bubble_ex_mem_o = 1'b1;
                end else if (redirect_ex_i) begin
                    redirect_take = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (load_use) begin
                    lu_take       = 1'b1;
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            MC_BUSY: begin
                if (mc_done_i) begin
                    // Stalls drop so EX/MEM captures the finished result this cycle.
                end else if (cnt_q == CNT_LAST) begin
                    // Hung op: front end holds, ID/EX takes a bubble, the EX op is dropped.
                    mc_abort        = 1'b1;
                    stall_pc_o      = 1'b1;
                    stall_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                    bubble_ex_mem_o = 1'b1;
                end else begin
                    stall_pc_o      = 1'b1;
                    stall_if_id_o   = 1'b1;
                    stall_id_ex_o   = 1'b1;
                    bubble_ex_mem_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_q <= '0;
                    if (mc_enter) begin
                        state_q <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (mc_done_i) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else if (mc_abort) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mc_busy_o    = (state_q == MC_BUSY);
    assign mc_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_lu_q,    perf_lu_d;

    assign perf_stall_d = perf_stall_q + {31'd0, stall_pc_o};
    assign perf_flush_d = perf_flush_q + {31'd0, redirect_take};
    assign perf_lu_d    = perf_lu_q    + {31'd0, lu_take};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_lu_q    <= perf_lu_d;
        end
    end

    assign perf_stall_cyc_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
    assign perf_lu_cnt_o    = perf_lu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, multi-cycle, timeout, async reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id;
    logic       rs1_used, rs2_used;
    logic [4:0] wr_ex, wr_mem, wr_wb;
    logic       we_ex, we_mem, we_wb;
    logic [1:0] wd_sel_ex, wd_sel_mem;
    logic       redirect, mc_start, mc_done;
    logic       stall_pc, stall_if_id, stall_id_ex;
    logic       flush_if_id, flush_id_ex, bubble_ex_mem;
    logic [1:0] fwd1_sel, fwd2_sel;
    logic       fwd1e, fwd2e;
    logic       mc_busy, mc_timeout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_id_i        (rs1_id),
        .rs2_id_i        (rs2_id),
        .rs1_used_id_i   (rs1_used),
        .rs2_used_id_i   (rs2_used),
        .wr_ex_i         (wr_ex),
        .wr_mem_i        (wr_mem),
        .wr_wb_i         (wr_wb),
        .rf_we_ex_i      (we_ex),
        .rf_we_mem_i     (we_mem),
        .rf_we_wb_i      (we_wb),
        .wd_sel_ex_i     (wd_sel_ex),
        .wd_sel_mem_i    (wd_sel_mem),
        .redirect_ex_i   (redirect),
        .mc_start_ex_i   (mc_start),
        .mc_done_i       (mc_done),
        .stall_pc_o      (stall_pc),
        .stall_if_id_o   (stall_if_id),
        .stall_id_ex_o   (stall_id_ex),
        .flush_if_id_o   (flush_if_id),
        .flush_id_ex_o   (flush_id_ex),
        .bubble_ex_mem_o (bubble_ex_mem),
        .fwd_rD1_sel_o   (fwd1_sel),
        .fwd_rD2_sel_o   (fwd2_sel),
        .fwd_rD1e_o      (fwd1e),
        .fwd_rD2e_o      (fwd2e),
        .mc_busy_o       (mc_busy),
        .mc_timeout_o    (mc_timeout)
    );

    // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble, busy, timeout}
    logic [7:0] ctl;
    // {2'b00, fwd1_sel, fwd1e, fwd2_sel, fwd2e}
    logic [7:0] fwd;
    assign ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                  flush_id_ex, bubble_ex_mem, mc_busy, mc_timeout};
    assign fwd = {2'b00, fwd1_sel, fwd1e, fwd2_sel, fwd2e};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("[%0t] %s obs=%b", $time, tag, obs);
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        wr_ex = 0; wr_mem = 0; wr_wb = 0;
        we_ex = 0; we_mem = 0; we_wb = 0;
        wd_sel_ex = 0; wd_sel_mem = 0;
        redirect = 0; mc_start = 0; mc_done = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk("reset_ctl", ctl, 8'b0000_0000);
        chk("reset_fwd", fwd, 8'b0000_0000);
        next();
        rst_n = 1'b1;

        // Forwarding priority and boundaries
        rs1_id = 5; rs1_used = 1;
        wr_ex = 5; we_ex = 1; wd_sel_ex = 2'b00;
        wr_mem = 5; we_mem = 1;
        #2;
        chk("fwd_ex_over_mem", fwd, 8'b00_01_1_00_0);
        chk("fwd_no_ctl", ctl, 8'b0000_0000);
        rs1_id = 0; #1;
        chk("fwd_x0", fwd, 8'b0000_0000);
        rs1_id = 5; wr_ex = 3; #1;
        chk("fwd_mem", fwd, 8'b00_10_1_00_0);
        we_mem = 0; wr_wb = 5; we_wb = 1; #1;
        chk("fwd_wb", fwd, 8'b00_11_1_00_0);
        rs1_used = 0; rs2_id = 5; rs2_used = 1; #1;
        chk("fwd_unused_rs1_rs2_wb", fwd, 8'b00_00_0_11_1);
        next();

        // Load-use: one cycle of stall + bubble, then MEM forwarding of load data
        clear_inputs();
        wr_ex = 7; we_ex = 1; wd_sel_ex = 2'b01;
        rs2_id = 7; rs2_used = 1;
        #2;
        chk("lu_ctl", ctl, 8'b1100_1000);
        chk("lu_no_fwd", fwd, 8'b0000_0000);
        next();
        we_ex = 0; wd_sel_ex = 0; wr_ex = 0;
        wr_mem = 7; we_mem = 1; wd_sel_mem = 2'b01;
        #2;
        chk("lu_after_ctl", ctl, 8'b0000_0000);
        chk("lu_after_fwd", fwd, 8'b00_00_0_10_1);
        next();

        // Redirect suppresses load-use stall
        clear_inputs();
        wr_ex = 7; we_ex = 1; wd_sel_ex = 2'b01;
        rs1_id = 7; rs1_used = 1; redirect = 1;
        #2;
        chk("redirect_over_lu", ctl, 8'b0001_1000);
        next();
        clear_inputs();
        #2;
        chk("idle_after_redirect", ctl, 8'b0000_0000);
        next();

        // Single-cycle multi-cycle op: no stall, no FSM entry
        mc_start = 1; mc_done = 1;
        #2;
        chk("mc_single_cycle", ctl, 8'b0000_0000);
        next();
        clear_inputs();
        #2;
        chk("mc_single_no_busy", ctl, 8'b0000_0000);
        next();

        // Multi-cycle op, done on the 5th cycle after entry
        mc_start = 1;
        #2;
        chk("mc_enter", ctl, 8'b1110_0100);
        next();
        for (int k = 1; k <= 4; k++) begin
            redirect = (k == 2);
            #2;
            chk($sformatf("mc_busy_%0d", k), ctl, 8'b1110_0110);
            next();
        end
        redirect = 0; mc_done = 1;
        #2;
        chk("mc_done", ctl, 8'b0000_0010);
        next();
        clear_inputs();
        #2;
        chk("mc_back_run", ctl, 8'b0000_0000);
        next();

        // Timeout watchdog
        mc_start = 1;
        #2;
        chk("to_enter", ctl, 8'b1110_0100);
        next();
        for (int k = 1; k <= 63; k++) begin
            #2;
            if (k == 1 || k == 63) chk($sformatf("to_busy_%0d", k), ctl, 8'b1110_0110);
            next();
        end
        #2;
        chk("to_abort", ctl, 8'b1100_1110);
        next();
        mc_start = 0;
        #2;
        chk("to_sticky", ctl, 8'b0000_0001);
        next();
        next();
        #2;
        chk("to_sticky_later", ctl, 8'b0000_0001);
        next();

        // Async reset in MC_BUSY cycle 3
        mc_start = 1;
        #2;
        chk("rst_enter", ctl, 8'b1110_0101);
        next();
        next();
        next();
        #2;
        chk("rst_busy3", ctl, 8'b1110_0111);
        rst_n = 0; mc_start = 0;
        #1;
        chk("rst_immediate", ctl, 8'b0000_0000);
        next();
        rst_n = 1;
        #2;
        chk("rst_released", ctl, 8'b0000_0000);
        next();

        // Counter restarted from 0: abort lands exactly on busy cycle 64 again
        mc_start = 1;
        next();
        for (int k = 1; k <= 63; k++) begin
            #2;
            if (k == 63) chk("rst_cnt_busy_63", ctl, 8'b1110_0110);
            next();
        end
        #2;
        chk("rst_cnt_abort", ctl, 8'b1100_1110);
        next();
        clear_inputs();
        #2;
        chk("rst_cnt_sticky", ctl, 8'b0000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
